butterfly_stage_sequencer: RTL and testbench

Sequences one complete in-place radix-2 FFT or NTT pass over the two-bank coefficient memory. Per stage it issues one butterfly per cycle, generates conflict-free read addresses, twiddle indices and the write-back destination fields (bank, address, valid) consumed by the store logic. Between stages it stalls until the butterfly pipeline has drained, so no read overtakes a pending write. It sits between the top-level command FSM and the shared FFT/NTT butterfly datapath.

---
 rtl/butterfly_stage_sequencer_pkg.sv | 39 +++
 rtl/butterfly_stage_sequencer_if.sv | 45 ++++
 rtl/butterfly_stage_sequencer_dest_pipe.sv | 39 +++
 rtl/butterfly_stage_sequencer.sv | 169 ++++++++++++++++
 tb/tb_butterfly_stage_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/butterfly_stage_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : butterfly_stage_sequencer_pkg
//  Description : Shared FSM state encoding, mode encoding and index helpers
//                for the radix-2 butterfly stage sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package butterfly_stage_sequencer_pkg;

  // Sequencer FSM states
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  // Mode encoding as seen on cfg_fft / cfg_dif
  localparam logic C_MODE_NTT = 1'b0;
  localparam logic C_MODE_FFT = 1'b1;
  localparam logic C_DIR_DIT  = 1'b0;
  localparam logic C_DIR_DIF  = 1'b1;

  // Bank of an element index: even parity -> bank 0, odd parity -> bank 1.
  // Partner indices differ in exactly one bit, so they always land in
  // opposite banks.
  function automatic logic bank_of(input logic [31:0] x);
    return ^x;
  endfunction

  // Insert a 0 bit at position s: bits below s stay, bits at/above s move up.
  function automatic logic [31:0] insert_zero(input logic [31:0] j,
                                              input logic [31:0] s);
    logic [31:0] low_mask;
    low_mask = (32'd1 << s) - 32'd1;
    return ((j & ~low_mask) << 1) | (j & low_mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/butterfly_stage_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : butterfly_stage_sequencer_if
//  Description : Command, read-side and write-back bundle of the sequencer.
//                master = command/store side, slave = the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface butterfly_stage_sequencer_if #(
  parameter int LOGN       = 13,
  parameter int ADDR_WIDTH = LOGN - 1
);
  logic                  start;
  logic                  cfg_fft;
  logic                  cfg_dif;
  logic                  busy;
  logic                  done;
  logic                  is_fft;
  logic                  is_dif;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr_0;
  logic [ADDR_WIDTH-1:0] rd_addr_1;
  logic                  rd_swap;
  logic [LOGN-2:0]       tw_addr;
  logic                  valid_a;
  logic                  valid_b;
  logic                  dest_bank_a;
  logic                  dest_bank_b;
  logic [ADDR_WIDTH-1:0] dest_addr_a;
  logic [ADDR_WIDTH-1:0] dest_addr_b;

  modport master (
    output start, cfg_fft, cfg_dif,
    input  busy, done, is_fft, is_dif, rd_en, rd_addr_0, rd_addr_1, rd_swap,
           tw_addr, valid_a, valid_b, dest_bank_a, dest_bank_b,
           dest_addr_a, dest_addr_b
  );

  modport slave (
    input  start, cfg_fft, cfg_dif,
    output busy, done, is_fft, is_dif, rd_en, rd_addr_0, rd_addr_1, rd_swap,
           tw_addr, valid_a, valid_b, dest_bank_a, dest_bank_b,
           dest_addr_a, dest_addr_b
  );
endinterface
`default_nettype wire

// File: rtl/butterfly_stage_sequencer_dest_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : bsq_dest_pipe
//  Description : DEPTH-deep register chain aligning write-back destination
//                fields with the read data; cleared by async reset.
//  Revision    : 1.0  initial release
// ============================================================================
module bsq_dest_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] d_i,
  output logic      [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q_o = d_i;
    end else begin : g_chain
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift the destination bundle one stage per cycle; reset drops in-flight entries
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/butterfly_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : butterfly_stage_sequencer
//  Description : Sequences one in-place radix-2 FFT/NTT pass over a two-bank
//                memory: one butterfly per cycle, bank-conflict-free
//                addresses, twiddle indices, and a drain stall between stages.
//  Revision    : 1.0  initial release
// ============================================================================
module butterfly_stage_sequencer
  import butterfly_stage_sequencer_pkg::*;
#(
  parameter int LOGN         = 13,
  parameter int ADDR_WIDTH   = LOGN - 1,
  parameter int RD_LAT       = 2,
  parameter int PIPE_LAT_FFT = 24,
  parameter int PIPE_LAT_NTT = 22
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  butterfly_stage_sequencer_if.slave bfly
);

  localparam int J_W    = LOGN - 1;
  localparam int S_W    = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int D_FFT  = RD_LAT + PIPE_LAT_FFT;
  localparam int D_NTT  = RD_LAT + PIPE_LAT_NTT;
  localparam int D_MAX  = (D_FFT > D_NTT) ? D_FFT : D_NTT;
  localparam int CNT_W  = $clog2(D_MAX + 1);
  localparam int PIPE_W = 3 + 2 * ADDR_WIDTH;

  localparam logic [J_W-1:0]   C_J_LAST  = '1;
  localparam logic [S_W-1:0]   C_S_LAST  = S_W'(LOGN - 1);
  localparam logic [CNT_W-1:0] C_CNT_FFT = CNT_W'(D_FFT - 1);
  localparam logic [CNT_W-1:0] C_CNT_NTT = CNT_W'(D_NTT - 1);

  state_t           state_q, state_d;
  logic [J_W-1:0]   j_q, j_d;
  logic [S_W-1:0]   s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_fft_q, is_fft_d;
  logic             is_dif_q, is_dif_d;

  logic                  w_issue;
  logic                  w_last_stage;
  logic [LOGN-1:0]       w_a_idx;
  logic [LOGN-1:0]       w_b_idx;
  logic                  w_bank_a;
  logic                  w_bank_b;
  logic [ADDR_WIDTH-1:0] w_addr_a;
  logic [ADDR_WIDTH-1:0] w_addr_b;
  logic [J_W-1:0]        w_tw;
  logic [PIPE_W-1:0]     w_pipe_in;
  logic [PIPE_W-1:0]     w_pipe_out;

  assign w_issue      = (state_q == ST_ISSUE);
  assign w_last_stage = (is_dif_q == C_DIR_DIF) ? (s_q == '0) : (s_q == C_S_LAST);

  // FSM next-state, counter and mode-latch logic
  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    is_fft_d = is_fft_q;
    is_dif_d = is_dif_q;
    case (state_q)
      ST_IDLE: begin
        if (bfly.start) begin
          is_fft_d = bfly.cfg_fft;
          is_dif_d = bfly.cfg_dif;
          j_d      = '0;
          s_d      = (bfly.cfg_dif == C_DIR_DIF) ? C_S_LAST : '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (j_q == C_J_LAST) begin
          cnt_d   = (is_fft_q == C_MODE_FFT) ? C_CNT_FFT : C_CNT_NTT;
          state_d = ST_DRAIN;
        end else begin
          j_d = j_q + J_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          if (w_last_stage) begin
            state_d = ST_FIN;
          end else begin
            s_d     = (is_dif_q == C_DIR_DIF) ? (s_q - S_W'(1)) : (s_q + S_W'(1));
            j_d     = '0;
            state_d = ST_ISSUE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      j_q      <= '0;
      s_q      <= '0;
      cnt_q    <= '0;
      is_fft_q <= 1'b0;
      is_dif_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      is_fft_q <= is_fft_d;
      is_dif_q <= is_dif_d;
    end
  end

  // Butterfly operand indices: a has a 0 at bit s, b is its partner with a 1 there
  assign w_a_idx  = LOGN'(insert_zero(32'(j_q), 32'(s_q)));
  assign w_b_idx  = w_a_idx | (LOGN'(1) << s_q);
  assign w_bank_a = bank_of(32'(w_a_idx));
  assign w_bank_b = bank_of(32'(w_b_idx));
  assign w_addr_a = w_a_idx[LOGN-1:1];
  assign w_addr_b = w_b_idx[LOGN-1:1];

  // Twiddle index (j mod 2^s) << (LOGN-1-s); at s = LOGN-1 the mask wraps to all ones
  assign w_tw = (j_q & ((J_W'(1) << s_q) - J_W'(1))) << (S_W'(J_W) - s_q);

  // Read-side outputs are forced to 0 whenever no butterfly is issued
  assign bfly.rd_en     = w_issue;
  assign bfly.rd_swap   = w_issue & w_bank_a;
  assign bfly.rd_addr_0 = !w_issue ? '0 : (w_bank_a ? w_addr_b : w_addr_a);
  assign bfly.rd_addr_1 = !w_issue ? '0 : (w_bank_a ? w_addr_a : w_addr_b);
  assign bfly.tw_addr   = w_issue ? w_tw : '0;

  // In-place operation: destination equals source, delayed by the read latency
  assign w_pipe_in = {w_issue,
                      w_issue & w_bank_a,
                      w_issue & w_bank_b,
                      w_issue ? w_addr_a : '0,
                      w_issue ? w_addr_b : '0};

  bsq_dest_pipe #(
    .DEPTH (RD_LAT),
    .WIDTH (PIPE_W)
  ) u_dest_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (w_pipe_in),
    .q_o   (w_pipe_out)
  );

  assign bfly.valid_a     = w_pipe_out[PIPE_W-1];
  assign bfly.valid_b     = w_pipe_out[PIPE_W-1];
  assign bfly.dest_bank_a = w_pipe_out[PIPE_W-2];
  assign bfly.dest_bank_b = w_pipe_out[PIPE_W-3];
  assign bfly.dest_addr_a = w_pipe_out[2*ADDR_WIDTH-1:ADDR_WIDTH];
  assign bfly.dest_addr_b = w_pipe_out[ADDR_WIDTH-1:0];

  assign bfly.busy   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign bfly.done   = (state_q == ST_FIN);
  assign bfly.is_fft = is_fft_q;
  assign bfly.is_dif = is_dif_q;

endmodule
`default_nettype wire

// File: tb/tb_butterfly_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_butterfly_stage_sequencer
//  Description : Self-checking bench for butterfly_stage_sequencer at LOGN=3
//                with an index model and a write-back scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_butterfly_stage_sequencer;

  localparam int LOGN   = 3;
  localparam int AW     = LOGN - 1;
  localparam int RD_LAT = 2;
  localparam int PL_FFT = 6;
  localparam int PL_NTT = 4;
  localparam int N2     = 1 << (LOGN - 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  butterfly_stage_sequencer_if #(.LOGN(LOGN), .ADDR_WIDTH(AW)) bif ();

  butterfly_stage_sequencer #(
    .LOGN         (LOGN),
    .ADDR_WIDTH   (AW),
    .RD_LAT       (RD_LAT),
    .PIPE_LAT_FFT (PL_FFT),
    .PIPE_LAT_NTT (PL_NTT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bfly  (bif)
  );

  typedef struct {
    int            due;
    logic          ba;
    logic          bb;
    logic [AW-1:0] aa;
    logic [AW-1:0] ab;
  } dest_t;

  dest_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Model: build index by copying j's bits into every position except s
  function automatic int ins0(input int j, input int s);
    int r = 0;
    int k = 0;
    for (int p = 0; p < LOGN; p++) begin
      if (p != s) begin
        r = r | (((j >> k) & 1) << p);
        k++;
      end
    end
    return r;
  endfunction

  function automatic logic par(input int x);
    int ones = 0;
    for (int p = 0; p < 32; p++) ones += (x >> p) & 1;
    return (ones % 2) == 1;
  endfunction

  // Run one full pass from start; spur_c injects a start while busy,
  // abort_c returns right after that cycle's checks
  task automatic run_pass(input logic fft, input logic dif,
                          input int spur_c, input int abort_c);
    int d, period, done_c, rel, st, off, s, j, a, b, n_valid;
    logic e_rd, e_busy, e_done, ba, bb;
    logic [AW-1:0]   e_a0, e_a1;
    logic [LOGN-2:0] e_tw;
    dest_t x;
    d      = RD_LAT + (fft ? PL_FFT : PL_NTT);
    period = N2 + d;
    done_c = LOGN * period + 1;
    n_valid = 0;
    sb.delete();
    bif.cfg_fft = fft;
    bif.cfg_dif = dif;
    bif.start   = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      rel    = c - 1;
      st     = rel / period;
      off    = rel % period;
      e_busy = (c < done_c);
      e_done = (c == done_c);
      e_rd   = e_busy && (off < N2);

      n_checks++;
      if (bif.rd_en !== e_rd) begin
        n_fail++; $display("FAIL rd_en c=%0d got %b exp %b", c, bif.rd_en, e_rd);
      end
      n_checks++;
      if (bif.busy !== e_busy) begin
        n_fail++; $display("FAIL busy c=%0d got %b exp %b", c, bif.busy, e_busy);
      end
      n_checks++;
      if (bif.done !== e_done) begin
        n_fail++; $display("FAIL done c=%0d got %b exp %b", c, bif.done, e_done);
      end
      n_checks++;
      if (bif.valid_b !== bif.valid_a) begin
        n_fail++; $display("FAIL valid_b c=%0d got %b exp %b", c, bif.valid_b, bif.valid_a);
      end
      if (e_busy) begin
        n_checks++;
        if ({bif.is_fft, bif.is_dif} !== {fft, dif}) begin
          n_fail++; $display("FAIL mode c=%0d got %b%b exp %b%b", c, bif.is_fft, bif.is_dif, fft, dif);
        end
      end

      if (e_rd) begin
        s    = dif ? (LOGN - 1 - st) : st;
        j    = off;
        a    = ins0(j, s);
        b    = a | (1 << s);
        ba   = par(a);
        bb   = par(b);
        e_a0 = ba ? AW'(b >> 1) : AW'(a >> 1);
        e_a1 = ba ? AW'(a >> 1) : AW'(b >> 1);
        e_tw = (LOGN-1)'((j % (1 << s)) << (LOGN - 1 - s));
        n_checks++;
        if (bif.rd_swap !== ba) begin
          n_fail++; $display("FAIL rd_swap s=%0d j=%0d got %b exp %b", s, j, bif.rd_swap, ba);
        end
        n_checks++;
        if ({bif.rd_addr_0, bif.rd_addr_1} !== {e_a0, e_a1}) begin
          n_fail++; $display("FAIL rd_addr s=%0d j=%0d got %0d/%0d exp %0d/%0d",
                             s, j, bif.rd_addr_0, bif.rd_addr_1, e_a0, e_a1);
        end
        n_checks++;
        if (bif.tw_addr !== e_tw) begin
          n_fail++; $display("FAIL tw_addr s=%0d j=%0d got %0d exp %0d", s, j, bif.tw_addr, e_tw);
        end
        x.due = c + RD_LAT; x.ba = ba; x.bb = bb; x.aa = AW'(a >> 1); x.ab = AW'(b >> 1);
        sb.push_back(x);
      end

      if (bif.valid_a === 1'b1) begin
        n_valid++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL unexpected_valid c=%0d got 1 exp 0", c);
        end else begin
          x = sb.pop_front();
          if (x.due != c || {bif.dest_bank_a, bif.dest_bank_b, bif.dest_addr_a, bif.dest_addr_b}
                            !== {x.ba, x.bb, x.aa, x.ab}) begin
            n_fail++;
            $display("FAIL dest c=%0d got %b%b/%0d/%0d exp due %0d %b%b/%0d/%0d", c,
                     bif.dest_bank_a, bif.dest_bank_b, bif.dest_addr_a, bif.dest_addr_b,
                     x.due, x.ba, x.bb, x.aa, x.ab);
          end
        end
      end else if (sb.size() > 0 && sb[0].due == c) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_valid c=%0d got 0 exp 1", c);
        void'(sb.pop_front());
      end

      bif.start   = 1'b0;
      bif.cfg_fft = fft;
      bif.cfg_dif = dif;
      if (c == spur_c) begin
        bif.start   = 1'b1;
        bif.cfg_fft = ~fft;
        bif.cfg_dif = ~dif;
      end
      if (c == abort_c) return;
    end
    n_checks++;
    if (n_valid != LOGN * N2 || sb.size() != 0) begin
      n_fail++; $display("FAIL valid_count got %0d (pending %0d) exp %0d", n_valid, sb.size(), LOGN * N2);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.start = 1'b0; bif.cfg_fft = 1'b0; bif.cfg_dif = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bif.busy, bif.done, bif.rd_en, bif.valid_a, bif.valid_b, bif.is_fft, bif.is_dif,
         bif.rd_swap, bif.rd_addr_0, bif.rd_addr_1, bif.tw_addr, bif.dest_bank_a,
         bif.dest_bank_b, bif.dest_addr_a, bif.dest_addr_b} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got nonzero exp all 0");
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_dit_ntt();      run_pass(1'b0, 1'b0, 0, 0); endtask
  task automatic test_dif_fft();      run_pass(1'b1, 1'b1, 0, 0); endtask
  task automatic test_start_while_busy(); run_pass(1'b0, 1'b0, 3, 0); endtask

  task automatic test_back_to_back();
    run_pass(1'b0, 1'b1, 0, 0);
    run_pass(1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_reset_in_drain();
    // stage 1 drains in cycles 15..20 for NTT (D=6)
    run_pass(1'b0, 1'b0, 0, 15);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bif.busy, bif.done, bif.rd_en, bif.valid_a, bif.valid_b, bif.is_fft, bif.is_dif,
         bif.rd_swap, bif.rd_addr_0, bif.rd_addr_1, bif.tw_addr, bif.dest_bank_a,
         bif.dest_bank_b, bif.dest_addr_a, bif.dest_addr_b} !== '0) begin
      n_fail++; $display("FAIL abort_outputs got nonzero exp all 0");
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bif.done, bif.valid_a, bif.busy} !== 3'b000) begin
        n_fail++; $display("FAIL abort_quiet k=%0d got %b exp 000", k, {bif.done, bif.valid_a, bif.busy});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_pass(1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_dit_ntt();
    test_dif_fft();
    test_start_while_busy();
    test_back_to_back();
    test_reset_in_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
